// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU micro-step sequencer.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_STORE,
        ST_DONE
    } state_t;

    localparam int C_LD_A        = 0;
    localparam int C_LD_B        = 1;
    localparam int C_LD_ACC      = 2;
    localparam int C_BOOTH_ADD   = 3;
    localparam int C_BOOTH_NEG   = 4;
    localparam int C_BOOTH_SHIFT = 5;
    localparam int C_ITER_SHIFT  = 6;
    localparam int C_ST_RES      = 7;
    localparam int C_ST_HI       = 8;
    localparam int C_ST_LO       = 9;
    localparam int C_DIV_INIT0   = 10;
    localparam int C_DIV_INIT1   = 11;
    localparam int C_DIV_SHL     = 12;
    localparam int C_DIV_ADD     = 13;
    localparam int C_DIV_SUB     = 14;
    localparam int C_SUB_INV     = 15;
    localparam int C_LOGIC_SEL   = 16;
    localparam int C_DIV_QSHIFT  = 17;

    // Radix-4 Booth retires two bits per iteration; division retires one.
    function automatic int unsigned iter_count(input logic [2:0] op, input int unsigned width);
        return (op == OP_MUL) ? width / 2 : width;
    endfunction

endpackage

// File: rtl/phase_counter_mod5.sv
// One-hot 5-phase counter, wraps 4 -> 0; clear forces phase 0.
// Latency: phase moves one step per enabled clock.
// Backpressure: none; en stalls the counter, clear wins over en.
module phase_counter_mod5 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clear,
    output logic [4:0] phase
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= 5'b00001;
        end else if (clear) begin
            phase <= 5'b00001;
        end else if (en) begin
            phase <= {phase[3:0], phase[4]};
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the 5-phase micro-step schedule driving the ALU control vector c.
// Latency: 8 cycles logic/ADD/SUB, 8+5*N for MUL/DIV, 1 cycle on error.
// Backpressure: begin_signal is only accepted in IDLE; requests while busy are dropped.
module alu_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        begin_signal,
    input  logic [2:0]  op,
    input  logic        Q1,
    input  logic        Q0,
    input  logic        R,
    input  logic        A_msb,
    input  logic        divisor_zero,
    output logic [17:0] c,
    output logic        busy,
    output logic        end_signal,
    output logic        error
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t        state;
    logic [2:0]    op_q;
    logic [CW-1:0] count;
    logic [4:0]    ph;
    logic          last;
    logic          ph_en;
    logic          ph_clear;

    assign last       = (count == CW'(iter_count(op_q, WIDTH) - 1));
    assign busy       = (state != ST_IDLE);
    assign end_signal = (state == ST_DONE);

    // LOAD and ITER both leave at ph4, so the natural wrap lands STORE on ph0.
    assign ph_en    = (state == ST_LOAD) || (state == ST_ITER) || (state == ST_STORE);
    assign ph_clear = (state == ST_IDLE) || (state == ST_DONE) || ((state == ST_STORE) && ph[1]);

    phase_counter_mod5 u_phase (
        .clk   (clk),
        .reset (reset),
        .en    (ph_en),
        .clear (ph_clear),
        .phase (ph)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            op_q  <= OP_AND;
            count <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (begin_signal) begin
                        op_q  <= op;
                        error <= 1'b0;
                        if ((op == OP_RSVD) || ((op == OP_DIV) && divisor_zero)) begin
                            state <= ST_DONE;
                            error <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ph[4]) begin
                        if (op_q <= OP_SUB) begin
                            state <= ST_STORE;
                        end else begin
                            state <= ST_ITER;
                            count <= '0;
                        end
                    end
                end
                ST_ITER: begin
                    if (ph[4]) begin
                        if (last) state <= ST_STORE;
                        else      count <= count + 1'b1;
                    end
                end
                ST_STORE: begin
                    if (ph[1]) state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        c = '0;
        case (state)
            ST_LOAD: begin
                if (ph[0]) c[C_LD_A] = 1'b1;
                if (ph[1]) c[C_LD_B] = 1'b1;
                if (ph[2]) begin
                    if (op_q <= OP_SUB) c[C_LD_ACC]    = 1'b1;
                    if (op_q == OP_SUB) c[C_SUB_INV]   = 1'b1;
                    if (op_q == OP_DIV) c[C_DIV_INIT0] = 1'b1;
                end
                if (ph[3]) begin
                    if (op_q <= OP_XOR) c[C_LOGIC_SEL] = 1'b1;
                    if (op_q == OP_DIV) c[C_DIV_INIT1] = 1'b1;
                end
            end
            ST_ITER: begin
                if (ph[0]) begin
                    if (op_q == OP_MUL) begin
                        c[C_BOOTH_ADD] = Q0 ^ R;
                        c[C_BOOTH_NEG] = Q1 & (Q0 ^ R);
                    end else begin
                        c[C_DIV_SHL] = 1'b1;
                    end
                end
                if (ph[1]) begin
                    if (op_q == OP_MUL) c[C_BOOTH_SHIFT] = 1'b1;
                    else if (A_msb)     c[C_DIV_ADD]     = 1'b1;
                    else                c[C_DIV_SUB]     = 1'b1;
                end
                if (ph[2] && !last)                     c[C_ITER_SHIFT] = 1'b1;
                if (ph[3] && !last && (op_q == OP_DIV)) c[C_DIV_QSHIFT] = 1'b1;
            end
            ST_STORE: begin
                if (ph[0]) c[C_ST_RES] = 1'b1;
                if (ph[1]) begin
                    c[C_ST_HI] = 1'b1;
                    c[C_ST_LO] = 1'b1;
                end
            end
            default: c = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer at WIDTH 8 and 16, checked against a cycle-index schedule model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        begin_signal = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        Q1 = 1'b0, Q0 = 1'b0, R = 1'b0, A_msb = 1'b0, divisor_zero = 1'b0;
    logic [17:0] c8, c16;
    logic        busy8, busy16, end8, end16, err8, err16;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: cycle index since acceptance (0 = idle), completion cycle, latched op, error flag.
    int mk[2], mtot[2], mop[2];
    bit merr[2];

    logic [17:0] cseq[128];
    logic        err1;
    int cnt6, cnt17, cnt34, cnt13, cnt14, cnt15, cnz;
    int e8, e16;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .begin_signal(begin_signal), .op(op),
        .Q1(Q1), .Q0(Q0), .R(R), .A_msb(A_msb), .divisor_zero(divisor_zero),
        .c(c8), .busy(busy8), .end_signal(end8), .error(err8)
    );

    alu_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .begin_signal(begin_signal), .op(op),
        .Q1(Q1), .Q0(Q0), .R(R), .A_msb(A_msb), .divisor_zero(divisor_zero),
        .c(c16), .busy(busy16), .end_signal(end16), .error(err16)
    );

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] exp_c(input int o, input int k, input int tot, input int n,
                                          input bit q1, input bit q0, input bit r, input bit am);
        logic [17:0] e;
        int i, p;
        bit lst;
        e = '0;
        if (k == 0 || tot == 1 || k == tot) return e;
        if (k == tot - 2) begin
            e[7] = 1'b1;
        end else if (k == tot - 1) begin
            e[8] = 1'b1;
            e[9] = 1'b1;
        end else if (k <= 5) begin
            case (k)
                1: e[0] = 1'b1;
                2: e[1] = 1'b1;
                3: begin
                    if (o <= 4) e[2]  = 1'b1;
                    if (o == 4) e[15] = 1'b1;
                    if (o == 6) e[10] = 1'b1;
                end
                4: begin
                    if (o <= 2) e[16] = 1'b1;
                    if (o == 6) e[11] = 1'b1;
                end
                default: ;
            endcase
        end else begin
            i   = (k - 6) / 5;
            p   = (k - 6) % 5;
            lst = (i == n - 1);
            case (p)
                0: if (o == 5) begin e[3] = q0 ^ r; e[4] = q1 & (q0 ^ r); end else e[12] = 1'b1;
                1: if (o == 5) e[5] = 1'b1; else if (am) e[13] = 1'b1; else e[14] = 1'b1;
                2: e[6]  = !lst;
                3: e[17] = (o == 6) && !lst;
                default: ;
            endcase
        end
        return e;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                mk[i]   = 0;
                merr[i] = 1'b0;
            end else if (mk[i] == 0) begin
                if (begin_signal) begin
                    mop[i]  = int'(op);
                    merr[i] = 1'b0;
                    mk[i]   = 1;
                    if (op == 3'd7 || (op == 3'd6 && divisor_zero)) begin
                        merr[i] = 1'b1;
                        mtot[i] = 1;
                    end else if (op <= 3'd4) mtot[i] = 8;
                    else if (op == 3'd5)     mtot[i] = 8 + 5 * (wid(i) / 2);
                    else                     mtot[i] = 8 + 5 * wid(i);
                end
            end else if (mk[i] == mtot[i]) begin
                mk[i] = 0;
            end else begin
                mk[i] = mk[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int n;
                n = (mop[i] == 5) ? wid(i) / 2 : wid(i);
                check($sformatf("c_w%0d", wid(i)), int'((i == 0) ? c8 : c16),
                      int'(exp_c(mop[i], mk[i], mtot[i], n, Q1, Q0, R, A_msb)));
                check($sformatf("busy_w%0d", wid(i)), int'((i == 0) ? busy8 : busy16), int'(mk[i] != 0));
                check($sformatf("end_w%0d", wid(i)), int'((i == 0) ? end8 : end16),
                      int'(mk[i] != 0 && mk[i] == mtot[i]));
                check($sformatf("error_w%0d", wid(i)), int'((i == 0) ? err8 : err16), int'(merr[i]));
            end
        end
    end

    task automatic start(input logic [2:0] o, input logic dz);
        @(posedge clk); #1;
        begin_signal = 1'b1;
        op           = o;
        divisor_zero = dz;
        @(posedge clk); #1;
        begin_signal = 1'b0;
    endtask

    // Runs from cycle 1 until both instances have pulsed end_signal.
    task automatic measure(input bit disturb);
        int cyc;
        cyc = 1;
        e8 = 0; e16 = 0;
        cnt6 = 0; cnt17 = 0; cnt34 = 0; cnt13 = 0; cnt14 = 0; cnt15 = 0; cnz = 0;
        while (cyc < 120) begin
            A_msb = (cyc >= 6) ? (((cyc - 6) / 5) % 2 == 1) : 1'b0;
            if (disturb && cyc == 10) begin begin_signal = 1'b1; op = 3'd6; divisor_zero = 1'b1; end
            if (disturb && cyc == 11) begin begin_signal = 1'b0; op = 3'd0; end
            @(negedge clk);
            cseq[cyc] = c8;
            if (cyc == 1) err1 = err8;
            if (end8  && e8  == 0) e8  = cyc;
            if (end16 && e16 == 0) e16 = cyc;
            if (c8[6])  cnt6++;
            if (c8[17]) cnt17++;
            if (c8[3] && c8[4]) cnt34++;
            if (c8[13]) cnt13++;
            if (c8[14]) cnt14++;
            if (c8[15]) cnt15++;
            if (c8 != 0 || c16 != 0) cnz++;
            if (e8 != 0 && e16 != 0) break;
            @(posedge clk); #1;
            cyc++;
        end
        if (e8 == 0 || e16 == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: end seen w8=%0d w16=%0d required both nonzero", e8, e16);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_c", int'(c8), 0);
        check("rst_busy", int'(busy8), 0);
        check("rst_end", int'(end8), 0);
        check("rst_err", int'(err8), 0);

        // AND
        start(3'd0, 1'b0);
        measure(1'b0);
        check("and_end8", e8, 8);
        check("and_end16", e16, 8);
        check("and_c1", int'(cseq[1]), 32'h00001);
        check("and_c2", int'(cseq[2]), 32'h00002);
        check("and_c3", int'(cseq[3]), 32'h00004);
        check("and_c4", int'(cseq[4]), 32'h10000);
        check("and_c5", int'(cseq[5]), 0);
        check("and_c6", int'(cseq[6]), 32'h00080);
        check("and_c7", int'(cseq[7]), 32'h00300);
        check("and_c15", cnt15, 0);

        // MUL with Q1Q0R = 101
        Q1 = 1'b1; Q0 = 1'b0; R = 1'b1;
        start(3'd5, 1'b0);
        measure(1'b0);
        check("mul_end8", e8, 28);
        check("mul_end16", e16, 48);
        check("mul_c34", cnt34, 4);
        check("mul_c6", cnt6, 3);

        // DIV, A_msb toggling per iteration
        Q1 = 1'b0; Q0 = 1'b0; R = 1'b0;
        start(3'd6, 1'b0);
        measure(1'b0);
        check("div_end8", e8, 48);
        check("div_end16", e16, 88);
        check("div_c17", cnt17, 7);
        check("div_c13", cnt13, 4);
        check("div_c14", cnt14, 4);

        // Divide by zero
        start(3'd6, 1'b1);
        measure(1'b0);
        check("dz_end", e8, 1);
        check("dz_err1", int'(err1), 1);
        check("dz_cz", cnz, 0);
        divisor_zero = 1'b0;
        @(negedge clk);
        check("dz_err_held", int'(err8), 1);

        // Reserved opcode
        start(3'd7, 1'b0);
        measure(1'b0);
        check("rsvd_end", e8, 1);
        check("rsvd_err1", int'(err1), 1);
        check("rsvd_cz", cnz, 0);

        // ADD clears error
        start(3'd3, 1'b0);
        measure(1'b0);
        check("add_err_clr", int'(err1), 0);
        check("add_end8", e8, 8);

        // MUL with begin/op disturbance while busy
        Q1 = 1'b1; Q0 = 1'b0; R = 1'b1;
        start(3'd5, 1'b0);
        measure(1'b1);
        check("mulb_end8", e8, 28);
        check("mulb_end16", e16, 48);
        check("mulb_c6", cnt6, 3);
        check("mulb_err", int'(err8), 0);

        // Reset in the middle of a DIV
        start(3'd6, 1'b0);
        repeat (20) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mrst_c", int'(c8), 0);
        check("mrst_busy", int'(busy16), 0);
        check("mrst_end", int'(end8), 0);
        start(3'd3, 1'b0);
        measure(1'b0);
        check("mrst_add_end8", e8, 8);
        check("mrst_add_end16", e16, 8);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
